// File: rtl/packet_injector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : packet_injector_pkg
//  Purpose  : Shared types for the packet injector and the router-tree
//             decoders: FSM states, destination modes and packet layout.
//  Revision : 1.0  initial release
// ============================================================================
package packet_injector_pkg;

  // Default field widths of the packet layout used across the fabric
  localparam int c_pkt_w  = 28;
  localparam int c_addr_w = 3;
  localparam int c_dest_w = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } injector_state_e;

  typedef enum logic [1:0] {
    MODE_RR      = 2'd0,
    MODE_FIXED   = 2'd1,
    MODE_PAYLOAD = 2'd2,
    MODE_RSVD    = 2'd3
  } dest_mode_e;

  // Wire layout of an emitted packet, MSB first
  typedef struct packed {
    logic [c_pkt_w-1:0]  payload;
    logic [c_addr_w-1:0] addr;
    logic [c_dest_w-1:0] dest;
  } packet_t;

  // The reserved encoding behaves as round-robin
  function automatic dest_mode_e decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_RR : dest_mode_e'(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/packet_injector_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_fwft
//  Purpose  : Single-clock first-word-fall-through FIFO. The head entry is
//             always visible on 'head'; a push into an empty FIFO shows up
//             on the cycle after the write, never combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw:0]    count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (count_q == (c_aw+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Accept requests and compute next pointers/occupancy; pointers wrap
  // naturally because DEPTH is a power of two
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    rd_ptr_d = pop_ok  ? rd_ptr_q + c_aw'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (c_aw+1)'(1);
      2'b01:   count_d = count_q - (c_aw+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/packet_injector.sv
`default_nettype none
// ============================================================================
//  Module   : packet_injector
//  Purpose  : Preloaded packet source. Payloads queued through the load port
//             are wrapped as {payload, src_addr, dest} and streamed on a
//             valid/ready channel until the programmed total is sent.
//  Revision : 1.0  initial release
// ============================================================================
module packet_injector
  import packet_injector_pkg::*;
#(
  parameter int WIDTH_packet = 28,
  parameter int WIDTH_addr   = 3,
  parameter int WIDTH_dest   = 3,
  parameter int WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
  parameter int DEPTH        = 16,
  parameter int NUM_DEST     = 4,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [WIDTH_packet-1:0] load_data,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [WIDTH_addr-1:0]   src_addr,
  input  logic [WIDTH_dest-1:0]   fixed_dest,
  input  logic [CNT_W-1:0]        pkt_total,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sent_count
);

  injector_state_e          state_q, state_d;
  dest_mode_e               mode_q, mode_d;
  logic [CNT_W-1:0]         sent_count_q, sent_count_d;
  logic [CNT_W-1:0]         pkt_total_q, pkt_total_d;
  logic [WIDTH_dest-1:0]    dest_q, dest_d;
  logic [WIDTH_dest-1:0]    fixed_dest_q, fixed_dest_d;
  logic [WIDTH_addr-1:0]    src_addr_q, src_addr_d;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic [WIDTH_packet-1:0]  fifo_head;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     unused_fifo_count;

  logic                     start_ok;
  logic                     handshake;
  logic [WIDTH_dest-1:0]    dest_sel;

  assign unused_fifo_count = ^fifo_count;

  sync_fifo_fwft #(
    .WIDTH (WIDTH_packet),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (load_valid && load_ready),
    .push_data (load_data),
    .pop       (handshake),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign load_ready = !fifo_full;
  assign out_valid  = (state_q == ST_SEND) && !fifo_empty;
  assign handshake  = out_valid && out_ready;
  assign start_ok   = start && (state_q != ST_SEND);
  assign busy       = (state_q == ST_SEND);
  assign done       = (state_q == ST_DONE);
  assign sent_count = sent_count_q;
  assign out_data   = {fifo_head, src_addr_q, dest_sel};

  // Destination header mux for the current head packet
  always_comb begin
    dest_sel = dest_q;
    case (mode_q)
      MODE_FIXED:   dest_sel = fixed_dest_q;
      MODE_PAYLOAD: dest_sel = fifo_head[WIDTH_dest-1:0];
      default:      dest_sel = dest_q;
    endcase
  end

  // Run control: latch configuration on start, count handshakes, end the run
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    sent_count_d = sent_count_q;
    pkt_total_d  = pkt_total_q;
    dest_d       = dest_q;
    fixed_dest_d = fixed_dest_q;
    src_addr_d   = src_addr_q;
    if (start_ok) begin
      mode_d       = decode_mode(mode);
      src_addr_d   = src_addr;
      fixed_dest_d = fixed_dest;
      pkt_total_d  = pkt_total;
      sent_count_d = '0;
      dest_d       = WIDTH_dest'(1);
      state_d      = (pkt_total == '0) ? ST_DONE : ST_SEND;
    end else if (handshake) begin
      sent_count_d = sent_count_q + CNT_W'(1);
      if (mode_q == MODE_RR) begin
        dest_d = (dest_q == WIDTH_dest'(NUM_DEST)) ? WIDTH_dest'(1)
                                                   : dest_q + WIDTH_dest'(1);
      end
      if (sent_count_d == pkt_total_q) begin
        state_d = ST_DONE;
      end
    end
  end

  // Control registers; reset abandons any run in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_RR;
      sent_count_q <= '0;
      pkt_total_q  <= '0;
      dest_q       <= WIDTH_dest'(1);
      fixed_dest_q <= '0;
      src_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      sent_count_q <= sent_count_d;
      pkt_total_q  <= pkt_total_d;
      dest_q       <= dest_d;
      fixed_dest_q <= fixed_dest_d;
      src_addr_q   <= src_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_injector.sv
// ============================================================================
//  Module   : tb_packet_injector
//  Purpose  : Directed bench for packet_injector with a queue-based reference
//             model compared every cycle, plus literal checks per scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_packet_injector;

  localparam int PW = 28, AW = 3, DW = 3, W = PW + AW + DW;
  localparam int DEPTH = 16, ND = 4, CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [PW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] src_addr = '0;
  logic [DW-1:0] fixed_dest = '0;
  logic [CW-1:0] pkt_total = '0;
  logic          out_ready = 1'b0;
  logic          load_ready, out_valid, busy, done;
  logic [W-1:0]  out_data;
  logic [CW-1:0] sent_count;

  packet_injector #(
    .WIDTH_packet (PW), .WIDTH_addr (AW), .WIDTH_dest (DW),
    .DEPTH (DEPTH), .NUM_DEST (ND), .CNT_W (CW)
  ) dut (
    .clk (clk), .reset (reset),
    .load_valid (load_valid), .load_ready (load_ready), .load_data (load_data),
    .start (start), .mode (mode), .src_addr (src_addr), .fixed_dest (fixed_dest),
    .pkt_total (pkt_total),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .busy (busy), .done (done), .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] mq[$];
  bit            m_run = 0, m_done = 0;
  int            m_sent = 0, m_total = 0, m_mode = 0, m_src = 0, m_fix = 0, m_rr = 1;
  bit            m_hs, m_push;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_run = 0; m_done = 0; m_sent = 0; m_total = 0;
        m_mode = 0; m_src = 0; m_fix = 0; m_rr = 1;
      end else begin
        m_hs   = m_run && (mq.size() > 0) && out_ready;
        m_push = load_valid && (mq.size() < DEPTH);
        if (m_hs) begin
          mq.delete(0);
          m_sent++;
          if (m_mode == 0) m_rr = (m_rr == ND) ? 1 : m_rr + 1;
          if (m_sent == m_total) begin m_run = 0; m_done = 1; end
        end
        if (m_push) mq.push_back(load_data);
        if (start && !m_run) begin
          m_mode  = (mode == 2'd3) ? 0 : int'(mode);
          m_src   = int'(src_addr);
          m_fix   = int'(fixed_dest);
          m_total = int'(pkt_total);
          m_sent  = 0;
          m_rr    = 1;
          m_run   = (pkt_total != 0);
          m_done  = (pkt_total == 0);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [DW-1:0] dut_dests[$];
  logic [PW-1:0] dut_pay[$];
  bit            e_valid, p_valid = 0, p_ready = 0;
  logic [DW-1:0] e_dest;
  logic [PW-1:0] e_head;
  logic [W-1:0]  p_data = '0;
  logic [31:0]   m_sent_v;

  initial begin
    forever begin
      @(negedge clk);
      e_valid  = m_run && (mq.size() > 0);
      m_sent_v = m_sent;
      chk("out_valid", out_valid, e_valid);
      chk("load_ready", load_ready, mq.size() < DEPTH);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("sent_count", sent_count, m_sent_v[CW-1:0]);
      if (e_valid) begin
        e_head = mq[0];
        case (m_mode)
          1:       e_dest = DW'(m_fix);
          2:       e_dest = e_head[DW-1:0];
          default: e_dest = DW'(m_rr);
        endcase
        chk("out_data", out_data, {e_head, AW'(m_src), e_dest});
      end
      if (p_valid && !p_ready && !reset) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, p_data);
      end
      if (out_valid && out_ready) begin
        dut_dests.push_back(out_data[DW-1:0]);
        dut_pay.push_back(out_data[W-1:AW+DW]);
      end
      p_valid = out_valid && !reset;
      p_ready = out_ready;
      p_data  = out_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_n(input int n, input logic [PW-1:0] base);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + PW'(i);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [AW-1:0] s,
                           input logic [DW-1:0] f, input logic [CW-1:0] t);
    mode = m; src_addr = s; fixed_dest = f; pkt_total = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int n = 0;
    while (!done && n < budget) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      n++;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int exp1 [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
  int loaded, n;
  bit acc;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sent", sent_count, 16'd0);
    reset = 1'b0;
    tick();

    // T1: round-robin destinations
    load_n(8, 28'h100);
    out_ready = 1'b1;
    dut_dests.delete(); dut_pay.delete();
    start_run(2'd0, 3'd0, 3'd0, 16'd8);
    wait_done(50, 0);
    chk("t1_sent", sent_count, 16'd8);
    chk("t1_n", dut_dests.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_dest", dut_dests[i], exp1[i]);

    // T2: fixed destination with back-pressure
    out_ready = 1'b0;
    load_n(6, 28'h2000);
    dut_dests.delete(); dut_pay.delete();
    start_run(2'd1, 3'd2, 3'b101, 16'd6);
    wait_done(100, 1);
    chk("t2_sent", sent_count, 16'd6);
    chk("t2_n", dut_dests.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_dest", dut_dests[i], 3'd5);
      chk("t2_pay", dut_pay[i], 28'h2000 + PW'(i));
    end

    // T3: full FIFO, then loading concurrently with sending
    out_ready = 1'b1;
    load_n(16, 28'h30000);
    chk("t3_full", load_ready, 1'b0);
    dut_dests.delete(); dut_pay.delete();
    loaded = 16;
    load_valid = 1'b1;
    load_data  = 28'h30000 + PW'(loaded);
    mode = 2'd0; pkt_total = 16'd40; start = 1'b1;
    acc = load_valid && load_ready;
    tick();
    start = 1'b0;
    if (acc) loaded++;
    n = 0;
    while (!done && n < 200) begin
      load_valid = (loaded < 40);
      load_data  = 28'h30000 + PW'(loaded);
      acc = load_valid && load_ready;
      tick();
      if (acc) loaded++;
      n++;
    end
    load_valid = 1'b0;
    chk("done_timeout", done, 1'b1);
    chk("t3_sent", sent_count, 16'd40);
    chk("t3_n", dut_pay.size(), 40);
    for (int i = 0; i < 40; i++) chk("t3_pay", dut_pay[i], 28'h30000 + PW'(i));

    // T4: start on an empty FIFO, the run stalls until data arrives
    start_run(2'd0, 3'd1, 3'd0, 16'd3);
    tick(); tick(); tick();
    chk("t4_stall_valid", out_valid, 1'b0);
    chk("t4_stall_busy", busy, 1'b1);
    load_valid = 1'b1; load_data = 28'h4444;
    tick();
    load_valid = 1'b0;
    chk("t4_first_valid", out_valid, 1'b1);
    tick(); tick();
    chk("t4_busy", busy, 1'b1);
    chk("t4_sent1", sent_count, 16'd1);
    load_n(2, 28'h4450);
    wait_done(20, 0);
    chk("t4_sent", sent_count, 16'd3);

    // T5: payload-embedded destination, then an empty run
    load_n(1, 28'h0ABCDE6);
    dut_dests.delete(); dut_pay.delete();
    start_run(2'd2, 3'd0, 3'd0, 16'd1);
    wait_done(20, 0);
    chk("t5_n", dut_dests.size(), 1);
    chk("t5_dest", dut_dests[0], 3'd6);
    dut_dests.delete();
    start_run(2'd0, 3'd0, 3'd0, 16'd0);
    chk("t5_zero_done", done, 1'b1);
    chk("t5_zero_sent", sent_count, 16'd0);
    chk("t5_zero_valid", out_valid, 1'b0);
    tick();
    chk("t5_zero_out", dut_dests.size(), 0);

    // T6: asynchronous reset in the middle of a run
    load_n(5, 28'h600);
    start_run(2'd0, 3'd3, 3'd0, 16'd5);
    n = 0;
    while (sent_count != 16'd2 && n < 20) begin tick(); n++; end
    chk("t6_sent2", sent_count, 16'd2);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_sent", sent_count, 16'd0);
    chk("t6_rst_ready", load_ready, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    start_run(2'd0, 3'd3, 3'd0, 16'd2);
    tick(); tick();
    chk("t6_no_data", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b1);
    load_n(2, 28'h700);
    wait_done(20, 0);
    chk("t6_sent", sent_count, 16'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
